// File: rtl/exmem_skid.sv
// EX/MEM pipeline register with a two-entry skid buffer.
// The upstream ready depends only on local state, never on out_ready, which
// keeps the handshake path between stages registered. Entries leave in strict
// FIFO order. Control bits leaving the stage are qualified by out_valid so that
// a bubble can never cause a register or memory write.
module exmem_skid #(
    parameter int DATA_W = 8,
    parameter int RD_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_regwrite,
    input  logic              in_memread,
    input  logic              in_memwrite,
    input  logic              in_mem_to_reg,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_write_data,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_regwrite,
    output logic              out_memread,
    output logic              out_memwrite,
    output logic              out_mem_to_reg,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_write_data,
    output logic [RD_W-1:0]   out_rd,
    output logic [1:0]        level
);

    // Entry layout: {regwrite, memread, memwrite, mem_to_reg, alu, wdata, rd}
    localparam int ENT_W = 4 + 2 * DATA_W + RD_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [ENT_W-1:0]   main_r;
    logic [ENT_W-1:0]   skid_r;
    logic [ENT_W-1:0]   in_entry_s;
    logic               in_fire_s;
    logic               out_fire_s;
    logic               load_main_in_s;
    logic               load_main_skid_s;
    logic               load_skid_s;

    assign in_entry_s = {in_regwrite, in_memread, in_memwrite, in_mem_to_reg,
                         in_alu_result, in_write_data, in_rd};
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;

    // Next-state and load-enable decode; flush squashes the whole cycle.
    always_comb begin
        state_nx_s       = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            state_nx_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) begin
                        state_nx_s     = ONE;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_nx_s = EMPTY;
                    end
                end
                ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        state_nx_s     = ONE;
                        load_main_in_s = 1'b1;
                    end else if (in_fire_s) begin
                        state_nx_s  = TWO;
                        load_skid_s = 1'b1;
                    end else if (out_fire_s) begin
                        state_nx_s = EMPTY;
                    end else begin
                        state_nx_s = ONE;
                    end
                end
                TWO: begin
                    if (out_fire_s) begin
                        state_nx_s       = ONE;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_nx_s = TWO;
                    end
                end
                default: begin
                    state_nx_s = EMPTY;
                end
            endcase
        end
    end

    // State register; reset dominates flush and any handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Entry storage: main is the head, skid catches the entry that arrives
    // while the head is stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            main_r <= {ENT_W{1'b0}};
            skid_r <= {ENT_W{1'b0}};
        end else begin
            if (load_main_in_s) begin
                main_r <= in_entry_s;
            end else if (load_main_skid_s) begin
                main_r <= skid_r;
            end else begin
                main_r <= main_r;
            end
            if (load_skid_s) begin
                skid_r <= in_entry_s;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

    // Output view of the head entry, forced quiet while reset is held.
    always_comb begin
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        out_regwrite   = 1'b0;
        out_memread    = 1'b0;
        out_memwrite   = 1'b0;
        out_mem_to_reg = 1'b0;
        out_alu_result = {DATA_W{1'b0}};
        out_write_data = {DATA_W{1'b0}};
        out_rd         = {RD_W{1'b0}};
        level          = 2'd0;
        if (rst) begin
            in_ready       = (state_r != TWO);
            out_valid      = (state_r != EMPTY);
            out_regwrite   = main_r[ENT_W-1] & out_valid;
            out_memread    = main_r[ENT_W-2] & out_valid;
            out_memwrite   = main_r[ENT_W-3] & out_valid;
            out_mem_to_reg = main_r[ENT_W-4] & out_valid;
            out_alu_result = main_r[2*DATA_W+RD_W-1 -: DATA_W];
            out_write_data = main_r[DATA_W+RD_W-1 -: DATA_W];
            out_rd         = main_r[RD_W-1:0];
            case (state_r)
                EMPTY:   level = 2'd0;
                ONE:     level = 2'd1;
                TWO:     level = 2'd2;
                default: level = 2'd0;
            endcase
        end else begin
            in_ready = 1'b0;
        end
    end

endmodule

// File: tb/tb_exmem_skid.sv
// Bench for exmem_skid: scoreboard of accepted entries checked on every
// output handshake, plus directed checks of reset, backpressure, streaming,
// flush, mid-operation reset and a wide parameterisation.
module tb_exmem_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid, in_ready;
    logic        in_regwrite, in_memread, in_memwrite, in_mem_to_reg;
    logic [7:0]  in_alu_result, in_write_data;
    logic [2:0]  in_rd;
    logic        out_valid, out_ready;
    logic        out_regwrite, out_memread, out_memwrite, out_mem_to_reg;
    logic [7:0]  out_alu_result, out_write_data;
    logic [2:0]  out_rd;
    logic [1:0]  level;

    logic        w_in_valid, w_in_ready, w_out_valid;
    logic        w_out_regwrite, w_out_memread, w_out_memwrite, w_out_mem_to_reg;
    logic [15:0] w_in_alu_result, w_out_alu_result, w_out_write_data;
    logic [4:0]  w_in_rd, w_out_rd;
    logic [1:0]  w_level;

    int tests  = 0;
    int failed = 0;
    logic [22:0] sb_q[$];

    always #5 clk = ~clk;

    exmem_skid dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_regwrite(in_regwrite), .in_memread(in_memread),
        .in_memwrite(in_memwrite), .in_mem_to_reg(in_mem_to_reg),
        .in_alu_result(in_alu_result), .in_write_data(in_write_data), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_regwrite(out_regwrite), .out_memread(out_memread),
        .out_memwrite(out_memwrite), .out_mem_to_reg(out_mem_to_reg),
        .out_alu_result(out_alu_result), .out_write_data(out_write_data),
        .out_rd(out_rd), .level(level)
    );

    exmem_skid #(.DATA_W(16), .RD_W(5)) dut_wide (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_regwrite(1'b1), .in_memread(1'b0),
        .in_memwrite(1'b0), .in_mem_to_reg(1'b0),
        .in_alu_result(w_in_alu_result), .in_write_data(16'h1234), .in_rd(w_in_rd),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_regwrite(w_out_regwrite), .out_memread(w_out_memread),
        .out_memwrite(w_out_memwrite), .out_mem_to_reg(w_out_mem_to_reg),
        .out_alu_result(w_out_alu_result), .out_write_data(w_out_write_data),
        .out_rd(w_out_rd), .level(w_level)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] alu, input logic [2:0] rd,
                         input logic rw, input logic mw);
        in_valid      = v;
        in_alu_result = alu;
        in_write_data = ~alu;
        in_rd         = rd;
        in_regwrite   = rw;
        in_memread    = alu[0];
        in_memwrite   = mw;
        in_mem_to_reg = alu[1];
    endtask

    // Scoreboard: judge the handshakes that the coming rising edge will perform.
    always @(negedge clk) begin
        if (!rst || flush) begin
            sb_q.delete();
        end else begin
            check_eq("level_vs_model", 32'(level), 32'(sb_q.size()));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", 32'(out_valid), 32'd0);
                end else begin
                    check_eq("sb_entry",
                             32'({out_regwrite, out_memread, out_memwrite, out_mem_to_reg,
                                  out_alu_result, out_write_data, out_rd}),
                             32'(sb_q.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back({in_regwrite, in_memread, in_memwrite, in_mem_to_reg,
                                in_alu_result, in_write_data, in_rd});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        w_in_valid = 1'b0; w_in_alu_result = 16'h0000; w_in_rd = 5'd0;
        step(); step();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_alu", 32'(out_alu_result), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("rel_in_ready", 32'(in_ready), 32'd1);

        // single entry, one-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 8'h5A, 3'd3, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        check_eq("single_valid", 32'(out_valid), 32'd1);
        check_eq("single_alu", 32'(out_alu_result), 32'h5A);
        check_eq("single_rd", 32'(out_rd), 32'd3);
        check_eq("single_regwrite", 32'(out_regwrite), 32'd1);
        check_eq("single_level", 32'(level), 32'd1);
        step();
        check_eq("single_drained", 32'(level), 32'd0);

        // backpressure fills the skid
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 3'd1, 1'b1, 1'b0);
        step();
        drive(1'b1, 8'h22, 3'd2, 1'b0, 1'b1);
        step();
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        check_eq("bp_level2", 32'(level), 32'd2);
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_head", 32'(out_alu_result), 32'h11);
        step();
        check_eq("bp_head_held", 32'(out_alu_result), 32'h11);
        out_ready = 1'b1;
        step();
        check_eq("bp_level1", 32'(level), 32'd1);
        check_eq("bp_second", 32'(out_alu_result), 32'h22);
        step();
        check_eq("bp_level0", 32'(level), 32'd0);

        // streaming at full rate
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(i), 3'(i), 1'b1, 1'b0);
            check_eq("stream_in_ready", 32'(in_ready), 32'd1);
            step();
            check_eq("stream_level", 32'(level), 32'd1);
            check_eq("stream_alu", 32'(out_alu_result), 32'(i));
        end
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        check_eq("stream_drained", 32'(level), 32'd0);

        // flush from TWO with memwrite entries
        out_ready = 1'b0;
        drive(1'b1, 8'hA1, 3'd4, 1'b0, 1'b1);
        step();
        drive(1'b1, 8'hA2, 3'd5, 1'b0, 1'b1);
        step();
        check_eq("fl_level2", 32'(level), 32'd2);
        check_eq("fl_memwrite_before", 32'(out_memwrite), 32'd1);
        flush = 1'b1;
        drive(1'b1, 8'h77, 3'd6, 1'b1, 1'b1);
        step();
        flush = 1'b0;
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        check_eq("fl_valid", 32'(out_valid), 32'd0);
        check_eq("fl_memwrite", 32'(out_memwrite), 32'd0);
        check_eq("fl_level", 32'(level), 32'd0);
        // flush from ONE where the input would otherwise be accepted
        drive(1'b1, 8'hB1, 3'd1, 1'b1, 1'b1);
        step();
        flush = 1'b1;
        drive(1'b1, 8'hB2, 3'd2, 1'b1, 1'b1);
        step();
        flush = 1'b0;
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        check_eq("fl1_level", 32'(level), 32'd0);
        check_eq("fl1_regwrite", 32'(out_regwrite), 32'd0);
        step();
        check_eq("fl1_not_captured", 32'(out_valid), 32'd0);

        // reset while full
        drive(1'b1, 8'hC1, 3'd1, 1'b1, 1'b1);
        step();
        drive(1'b1, 8'hC2, 3'd2, 1'b1, 1'b1);
        step();
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        check_eq("mr_level2", 32'(level), 32'd2);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("mr_valid", 32'(out_valid), 32'd0);
        check_eq("mr_alu", 32'(out_alu_result), 32'd0);
        check_eq("mr_memwrite", 32'(out_memwrite), 32'd0);
        check_eq("mr_in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b1;
        #1;
        check_eq("mr_rel_ready", 32'(in_ready), 32'd1);
        check_eq("mr_rel_valid", 32'(out_valid), 32'd0);
        check_eq("mr_rel_level", 32'(level), 32'd0);
        check_eq("mr_rel_data", 32'(out_write_data), 32'd0);

        // wide instance
        w_in_valid = 1'b1; w_in_alu_result = 16'hBEEF; w_in_rd = 5'd31;
        check_eq("wide_in_ready", 32'(w_in_ready), 32'd1);
        step();
        w_in_valid = 1'b0;
        check_eq("wide_valid", 32'(w_out_valid), 32'd1);
        check_eq("wide_alu", 32'(w_out_alu_result), 32'hBEEF);
        check_eq("wide_rd", 32'(w_out_rd), 32'd31);
        check_eq("wide_wdata", 32'(w_out_write_data), 32'h1234);
        check_eq("wide_ctrl", 32'({w_out_regwrite, w_out_memread, w_out_memwrite,
                                   w_out_mem_to_reg}), 32'h8);
        check_eq("wide_level", 32'(w_level), 32'd1);

        // random traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom),
                  1'($urandom), 1'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 29) == 0);
            step();
        end
        flush = 1'b0;
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        step(); step(); step();
        check_eq("final_empty", 32'(level), 32'd0);
        check_eq("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/exmem_skid.md
EXMEM_SKID -- requirements
Module: exmem_skid

Interface
REQ-001 Parameter DATA_W, default 8: width of the ALU result and store-data fields.
REQ-002 Parameter RD_W, default 3: width of the destination-register field.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  synchronous squash of all held entries.
REQ-006 in_valid  input  1  upstream (EX) entry present.
REQ-007 in_ready  output  1  stage can accept an entry this cycle.
REQ-008 in_regwrite, in_memread, in_memwrite, in_mem_to_reg  input  1 each  EX control bits.
REQ-009 in_alu_result  input  DATA_W  ALU result.
REQ-010 in_write_data  input  DATA_W  store data.
REQ-011 in_rd  input  RD_W  destination register.
REQ-012 out_valid  output  1  MEM-side entry present.
REQ-013 out_ready  input  1  downstream (MEM) accepts the entry.
REQ-014 out_regwrite, out_memread, out_memwrite, out_mem_to_reg  output  1 each  gated control bits.
REQ-015 out_alu_result, out_write_data  output  DATA_W  data of the head entry.
REQ-016 out_rd  output  RD_W  destination of the head entry.
REQ-017 level  output  2  occupancy: 0, 1 or 2.

Function
REQ-018 Storage SHALL be two entries, main (head) and skid, each holding all seven input fields.
REQ-019 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-020 State machine SHALL have states EMPTY, ONE, TWO; level SHALL encode 0/1/2 respectively.
REQ-021 in_ready SHALL be combinational: rst high and state != TWO; no dependence on out_ready (no combinational ready path).
REQ-022 out_valid SHALL be 1 iff state != EMPTY; out_* data fields SHALL be the main entry.
REQ-023 out_regwrite/out_memread/out_memwrite/out_mem_to_reg SHALL be main control bits AND out_valid; a bubble never writes memory or registers.
REQ-024 EMPTY: in_fire -> ONE, main <= inputs; otherwise stay.
REQ-025 ONE: in_fire & out_fire -> ONE, main <= inputs; in_fire & !out_fire -> TWO, skid <= inputs; !in_fire & out_fire -> EMPTY; neither -> hold.
REQ-026 TWO: out_fire -> ONE, main <= skid; otherwise hold; in_fire impossible (in_ready = 0).
REQ-027 Latency SHALL be one cycle: entry accepted at edge N appears on out_* after edge N when stage was EMPTY or main drained at edge N.
REQ-028 Ordering SHALL be strict FIFO; no entry dropped or duplicated while flush and rst are inactive.
REQ-029 Held entries SHALL be stable while out_valid & !out_ready.
REQ-030 flush = 1 at an edge SHALL force state EMPTY and ignore that cycle's in_fire and out_fire; register contents may be left stale but control outputs are gated per REQ-023.
REQ-031 All widths SHALL follow DATA_W/RD_W with no truncation or extension.

Reset
REQ-032 rst = 0 at an edge SHALL set state EMPTY and clear main and skid entries to zero, overriding flush and any handshake.
REQ-033 While rst = 0: out_valid = 0, all out_* = 0, level = 0, in_ready = 0.
REQ-034 Reset asserted with state TWO SHALL discard both entries; the first cycle after release shows in_ready = 1, out_valid = 0.

Verification
REQ-035 Reset then single entry: in_valid=1, alu=0x5A, rd=3, regwrite=1, out_ready=1 -> next cycle out_valid=1, out_alu_result=0x5A, out_rd=3, out_regwrite=1, level=1.
REQ-036 Backpressure: out_ready=0, push 0x11 then 0x22 -> level=2, in_ready=0, out_alu_result=0x11 held; raise out_ready -> 0x11, 0x22 emerge on consecutive cycles, level 2->1->0.
REQ-037 Streaming: in_valid=out_ready=1 for 8 cycles, data 0..7 -> out sequence 0..7 with one-cycle latency, level stays 1, in_ready never 0.
REQ-038 Flush: level=2 with memwrite=1 entries, assert flush one cycle with in_valid=1 -> next cycle out_valid=0, out_memwrite=0, level=0, flushed-cycle input not captured.
REQ-039 Reset mid-operation: level=2, rst=0 for one cycle -> out_* all zero, in_ready=0 during reset; after release level=0, in_ready=1.
REQ-040 Parameter sweep: DATA_W=16, RD_W=5, push 0xBEEF rd=31 -> out_alu_result=0xBEEF, out_rd=31.
